// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID controller: FSM states, filter shift, signed clamp.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL,
    TERM,
    SUM
  } pid_state_t;

  // Derivative IIR pole: df moves 1/4 of the way toward the new sample each computation.
  localparam int DFILT_SHIFT = 2;

  // Common container width for the clamp helper; callers sign-extend their operands into it.
  localparam int CLAMP_W = 64;

  function automatic logic signed [CLAMP_W-1:0] clamp_s(
    input logic signed [CLAMP_W-1:0] x,
    input logic signed [CLAMP_W-1:0] lo,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/pid_ctrl_gen2_if.sv
// Request/response bundle between the heater controller and the PID block.
// Latency: none (wiring only).
// Backpressure: start is only honoured while busy is low; no queueing.
interface pid_ctrl_gen2_if #(
  parameter int WIDTH = 12
);
  logic                    start;
  logic                    clear_int;
  logic signed [WIDTH-1:0] kp;
  logic signed [WIDTH-1:0] ki;
  logic signed [WIDTH-1:0] kd;
  logic        [WIDTH-1:0] setpoint;
  logic        [WIDTH-1:0] measured;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] response;
  logic                    sat_hi;
  logic                    sat_lo;

  modport master (
    output start, clear_int, kp, ki, kd, setpoint, measured,
    input  busy, done, response, sat_hi, sat_lo
  );

  modport slave (
    input  start, clear_int, kp, ki, kd, setpoint, measured,
    output busy, done, response, sat_hi, sat_lo
  );
endinterface

// File: rtl/pid_sat.sv
// Combinational signed saturator: clamps din into [MIN, MAX] and flags which bound was hit.
// Latency: 0 cycles.
// Backpressure: none; purely combinational.
module pid_sat
  import pid_pkg::*;
#(
  parameter int                       IN_W  = 25,
  parameter int                       OUT_W = 12,
  parameter logic signed [OUT_W-1:0]  MAX   = 12'sh3F0,
  parameter logic signed [OUT_W-1:0]  MIN   = 12'sh000
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    hi,
  output logic                    lo
);

  logic signed [CLAMP_W-1:0] x_ext;
  logic signed [CLAMP_W-1:0] hi_ext;
  logic signed [CLAMP_W-1:0] lo_ext;
  logic signed [CLAMP_W-1:0] y;

  // Sign-extend into the common width, clamp, and report strict bound violations only.
  always_comb begin
    x_ext  = {{(CLAMP_W-IN_W){din[IN_W-1]}}, din};
    hi_ext = {{(CLAMP_W-OUT_W){MAX[OUT_W-1]}}, MAX};
    lo_ext = {{(CLAMP_W-OUT_W){MIN[OUT_W-1]}}, MIN};
    y      = clamp_s(x_ext, lo_ext, hi_ext);
    dout   = OUT_W'(y);
    hi     = (x_ext > hi_ext);
    lo     = (x_ext < lo_ext);
  end

endmodule

// File: rtl/pid_ctrl_gen2.sv
// Saturated signed fixed-point PID, one computation per start; optional D filter via PID_DERIV_FILTER_EN.
// Latency: start sampled at edge N -> done pulse after edge N+4; next start accepted in the done cycle.
// Backpressure: start ignored while busy (not queued); response and sat flags held until next done.
module pid_ctrl_gen2
  import pid_pkg::*;
#(
  parameter int               WIDTH         = 12,
  parameter int               FRAC          = 4,
  parameter logic [WIDTH-1:0] OUT_MAX       = 12'h3F0,
  parameter logic [WIDTH-1:0] OUT_MIN       = 12'h000,
  parameter bit               ALLOW_NEG_ERR = 1'b0
) (
  input logic             CLK,
  input logic             RST,
  pid_ctrl_gen2_if.slave  bus
);

  localparam int PW = 2*WIDTH + 1;  // full product width
  localparam int IW = PW + 1;       // integrator accumulation width
  localparam int SW = WIDTH + 2;    // three-term sum width

  pid_state_t state;

  logic signed [WIDTH-1:0] kp_r, ki_r, kd_r;
  logic        [WIDTH-1:0] sp_r, meas_r, last_meas;
  logic                    clr_r, first_flag;
  logic signed [WIDTH:0]   e_r;
  logic signed [PW-1:0]    p_r, i_r, d_r;
  logic signed [WIDTH-1:0] p_t, integ;
  logic                    busy_r, done_r, sat_hi_r, sat_lo_r;
  logic signed [WIDTH-1:0] response_r;

  logic signed [WIDTH:0]   e_raw, dmeas;
  logic signed [PW-1:0]    p_prod, i_prod, d_prod, p_shr, d_shr;
  logic signed [IW-1:0]    int_acc;
  logic signed [WIDTH-1:0] int_base, p_sat, d_sat, int_sat, sum_sat, d_feed;
  logic signed [SW-1:0]    sum_acc;
  logic                    sum_hi, sum_lo;
  logic [5:0]              term_flags_unused;

`ifdef PID_DERIV_FILTER_EN
  logic signed [WIDTH-1:0] df, df_base, df_next;
  logic signed [WIDTH:0]   df_diff;

  // First-order IIR on the clamped D term; clear_int restarts it from zero along with the integrator.
  always_comb begin
    df_base = clr_r ? '0 : df;
    df_diff = (WIDTH+1)'(d_sat) - (WIDTH+1)'(df_base);
    df_next = df_base + WIDTH'(df_diff >>> DFILT_SHIFT);
    d_feed  = df;
  end
`else
  logic signed [WIDTH-1:0] d_t;

  // Unfiltered build: the clamped D term goes straight into the sum.
  always_comb d_feed = d_t;
`endif

  // Datapath arithmetic shared by the ERR/MUL/TERM/SUM steps; setpoint/measured are unsigned, so zero-extend.
  always_comb begin
    e_raw    = $signed({1'b0, sp_r}) - $signed({1'b0, meas_r});
    dmeas    = $signed({1'b0, last_meas}) - $signed({1'b0, meas_r});
    p_prod   = PW'(kp_r) * PW'(e_r);
    i_prod   = PW'(ki_r) * PW'(e_r);
    d_prod   = first_flag ? '0 : PW'(kd_r) * PW'(dmeas);
    p_shr    = p_r >>> FRAC;
    d_shr    = d_r >>> FRAC;
    int_base = clr_r ? '0 : integ;
    int_acc  = IW'(int_base) + IW'(i_r >>> FRAC);
    sum_acc  = SW'(p_t) + SW'(integ) + SW'(d_feed);
  end

  pid_sat #(.IN_W(PW), .OUT_W(WIDTH), .MAX(OUT_MAX), .MIN(OUT_MIN)) u_sat_p (
    .din(p_shr), .dout(p_sat), .hi(term_flags_unused[0]), .lo(term_flags_unused[1])
  );

  pid_sat #(.IN_W(PW), .OUT_W(WIDTH), .MAX(OUT_MAX), .MIN(OUT_MIN)) u_sat_d (
    .din(d_shr), .dout(d_sat), .hi(term_flags_unused[2]), .lo(term_flags_unused[3])
  );

  // Clamping the running integrator itself is what keeps it from winding up past the limits.
  pid_sat #(.IN_W(IW), .OUT_W(WIDTH), .MAX(OUT_MAX), .MIN(OUT_MIN)) u_sat_i (
    .din(int_acc), .dout(int_sat), .hi(term_flags_unused[4]), .lo(term_flags_unused[5])
  );

  pid_sat #(.IN_W(SW), .OUT_W(WIDTH), .MAX(OUT_MAX), .MIN(OUT_MIN)) u_sat_s (
    .din(sum_acc), .dout(sum_sat), .hi(sum_hi), .lo(sum_lo)
  );

  // Sequencer plus all datapath state; reset aborts any computation without a done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      kp_r       <= '0;
      ki_r       <= '0;
      kd_r       <= '0;
      sp_r       <= '0;
      meas_r     <= '0;
      clr_r      <= 1'b0;
      e_r        <= '0;
      p_r        <= '0;
      i_r        <= '0;
      d_r        <= '0;
      p_t        <= '0;
      integ      <= '0;
      last_meas  <= '0;
      first_flag <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      response_r <= '0;
      sat_hi_r   <= 1'b0;
      sat_lo_r   <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
      df         <= '0;
`else
      d_t        <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            kp_r   <= bus.kp;
            ki_r   <= bus.ki;
            kd_r   <= bus.kd;
            sp_r   <= bus.setpoint;
            meas_r <= bus.measured;
            clr_r  <= bus.clear_int;
            busy_r <= 1'b1;
            state  <= ERR;
          end
        end
        ERR: begin
          e_r   <= (!ALLOW_NEG_ERR && e_raw[WIDTH]) ? '0 : e_raw;
          state <= MUL;
        end
        MUL: begin
          p_r   <= p_prod;
          i_r   <= i_prod;
          d_r   <= d_prod;
          state <= TERM;
        end
        TERM: begin
          p_t        <= p_sat;
          integ      <= int_sat;
          last_meas  <= meas_r;
          first_flag <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
          df         <= df_next;
`else
          d_t        <= d_sat;
`endif
          state      <= SUM;
        end
        SUM: begin
          response_r <= sum_sat;
          sat_hi_r   <= sum_hi;
          sat_lo_r   <= sum_lo;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.response = response_r;
  assign bus.sat_hi   = sat_hi_r;
  assign bus.sat_lo   = sat_lo_r;

endmodule

// File: tb/tb_pid_ctrl_gen2.sv
// Directed bench for pid_ctrl_gen2: two instances (unsigned-error and signed-error) driven in lockstep.
// Latency: expects done four edges after the start edge.
// Backpressure: exercises start-while-busy and reset mid-computation.
module tb_pid_ctrl_gen2;

  logic CLK;
  logic RST;
  logic start, clear_int;
  logic signed [11:0] kp, ki, kd;
  logic [11:0] setpoint, measured;

  int n_checks;
  int n_pass;

  pid_ctrl_gen2_if #(.WIDTH(12)) b0 ();
  pid_ctrl_gen2_if #(.WIDTH(12)) b1 ();

  assign b0.start = start;  assign b1.start = start;
  assign b0.clear_int = clear_int;  assign b1.clear_int = clear_int;
  assign b0.kp = kp;  assign b1.kp = kp;
  assign b0.ki = ki;  assign b1.ki = ki;
  assign b0.kd = kd;  assign b1.kd = kd;
  assign b0.setpoint = setpoint;  assign b1.setpoint = setpoint;
  assign b0.measured = measured;  assign b1.measured = measured;

  pid_ctrl_gen2 #(.ALLOW_NEG_ERR(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(b0.slave));
  pid_ctrl_gen2 #(.ALLOW_NEG_ERR(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Issue one start; return edges-to-done (-1 if none within budget) and cycles busy was seen high.
  task automatic pulse_start(input logic clr, output int lat, output int busy_cnt);
    start = 1'b1;
    clear_int = clr;
    @(posedge CLK); #1;
    start = 1'b0;
    clear_int = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      if (b0.done === 1'b1) begin
        lat = c;
        break;
      end
      if (b0.busy === 1'b1) busy_cnt++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic set_in(input logic [11:0] p, input logic [11:0] i, input logic [11:0] d,
                        input logic [11:0] sp, input logic [11:0] ms);
    kp = p; ki = i; kd = d; setpoint = sp; measured = ms;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    clear_int = 1'b0;
    set_in(12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (b0.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", b0.busy); else n_pass++;
    n_checks++; if (b0.done !== 1'b0) $display("FAIL rst_done: got %b want 0", b0.done); else n_pass++;
    n_checks++; if (b0.response !== 12'h000) $display("FAIL rst_response: got %h want 000", b0.response); else n_pass++;
    n_checks++; if ({b0.sat_hi, b0.sat_lo} !== 2'b00) $display("FAIL rst_sat: got %b want 00", {b0.sat_hi, b0.sat_lo}); else n_pass++;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_proportional();
    int lat, bc;
    set_in(12'h010, 12'h000, 12'h000, 12'h200, 12'h100);
    pulse_start(1'b0, lat, bc);
    n_checks++; if (lat !== 4) $display("FAIL p_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (bc !== 4) $display("FAIL p_busy_cycles: got %0d want 4", bc); else n_pass++;
    n_checks++; if (b0.response !== 12'h100) $display("FAIL p_response: got %h want 100", b0.response); else n_pass++;
    n_checks++; if ({b0.sat_hi, b0.sat_lo} !== 2'b00) $display("FAIL p_sat: got %b want 00", {b0.sat_hi, b0.sat_lo}); else n_pass++;
    n_checks++; if (b0.busy !== 1'b0) $display("FAIL p_busy_at_done: got %b want 0", b0.busy); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat, bc;
    // P alone clamps exactly to OUT_MAX: inclusive bound, no flag.
    set_in(12'h7FF, 12'h000, 12'h000, 12'h3F0, 12'h000);
    pulse_start(1'b0, lat, bc);
    n_checks++; if (b0.response !== 12'h3F0) $display("FAIL sat_p_resp: got %h want 3f0", b0.response); else n_pass++;
    n_checks++; if (b0.sat_hi !== 1'b0) $display("FAIL sat_p_edge_hi: got %b want 0", b0.sat_hi); else n_pass++;
    // P and I both at 0x3F0 -> sum 0x7E0 exceeds OUT_MAX.
    set_in(12'h7FF, 12'h7FF, 12'h000, 12'h3F0, 12'h000);
    pulse_start(1'b1, lat, bc);
    n_checks++; if (b0.response !== 12'h3F0) $display("FAIL sat_pi_resp: got %h want 3f0", b0.response); else n_pass++;
    n_checks++; if (b0.sat_hi !== 1'b1) $display("FAIL sat_pi_hi: got %b want 1", b0.sat_hi); else n_pass++;
    // Negative error forced to 0, integrator cleared -> exactly OUT_MIN.
    set_in(12'h7FF, 12'h7FF, 12'h000, 12'h100, 12'h200);
    pulse_start(1'b1, lat, bc);
    n_checks++; if (b0.response !== 12'h000) $display("FAIL sat_neg_resp: got %h want 000", b0.response); else n_pass++;
    n_checks++; if ({b0.sat_hi, b0.sat_lo} !== 2'b00) $display("FAIL sat_neg_flags: got %b want 00", {b0.sat_hi, b0.sat_lo}); else n_pass++;
  endtask

  task automatic test_integral_clear();
    int lat, bc;
    logic [11:0] exp_r [4];
    exp_r[0] = 12'h010; exp_r[1] = 12'h020; exp_r[2] = 12'h030; exp_r[3] = 12'h010;
    set_in(12'h000, 12'h010, 12'h000, 12'h110, 12'h100);
    for (int k = 0; k < 4; k++) begin
      pulse_start((k == 3) ? 1'b1 : 1'b0, lat, bc);
      n_checks++;
      if (lat !== 4 || b0.response !== exp_r[k])
        $display("FAIL int_step%0d: got lat=%0d resp=%h want lat=4 resp=%h", k, lat, b0.response, exp_r[k]);
      else n_pass++;
    end
  endtask

  task automatic test_antiwindup();
    int lat, bc;
    set_in(12'h000, 12'h100, 12'h000, 12'h200, 12'h100);
    for (int k = 0; k < 10; k++) begin
      pulse_start(1'b0, lat, bc);
      if (k == 0) begin
        n_checks++; if (b1.response !== 12'h3F0) $display("FAIL aw_first: got %h want 3f0", b1.response); else n_pass++;
      end
    end
    n_checks++; if (b1.response !== 12'h3F0) $display("FAIL aw_pinned: got %h want 3f0", b1.response); else n_pass++;
    n_checks++; if (b1.sat_hi !== 1'b0) $display("FAIL aw_pinned_hi: got %b want 0", b1.sat_hi); else n_pass++;
    // e = -0x10 with ki = 1.0: integrator steps down by 0x10 immediately.
    set_in(12'h000, 12'h010, 12'h000, 12'h100, 12'h110);
    pulse_start(1'b0, lat, bc);
    n_checks++; if (b1.response !== 12'h3E0) $display("FAIL aw_unwind: got %h want 3e0", b1.response); else n_pass++;
    // Unsigned-error instance sees e forced to 0, so stays pinned.
    n_checks++; if (b0.response !== 12'h3F0) $display("FAIL aw_noneg: got %h want 3f0", b0.response); else n_pass++;
  endtask

  task automatic test_derivative();
    int lat, bc;
    logic [11:0] exp2;
`ifdef PID_DERIV_FILTER_EN
    exp2 = 12'h004;
`else
    exp2 = 12'h010;
`endif
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    set_in(12'h000, 12'h000, 12'h010, 12'h100, 12'h100);
    pulse_start(1'b0, lat, bc);
    n_checks++; if (b0.response !== 12'h000) $display("FAIL d_first: got %h want 000", b0.response); else n_pass++;
    set_in(12'h000, 12'h000, 12'h010, 12'h100, 12'h0F0);
    pulse_start(1'b0, lat, bc);
    n_checks++; if (b0.response !== exp2) $display("FAIL d_second: got %h want %h", b0.response, exp2); else n_pass++;
  endtask

  task automatic test_reset_handshake();
    int dn;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    n_checks++; if (b0.busy !== 1'b0) $display("FAIL hs_rst_busy: got %b want 0", b0.busy); else n_pass++;
    n_checks++; if (b0.response !== 12'h000) $display("FAIL hs_rst_resp: got %h want 000", b0.response); else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      if (b0.done === 1'b1) dn++;
      @(posedge CLK); #1;
    end
    n_checks++; if (dn !== 0) $display("FAIL hs_rst_nodone: got %0d done pulses want 0", dn); else n_pass++;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (b0.done === 1'b1) dn++;
      @(posedge CLK); #1;
    end
    n_checks++; if (dn !== 1) $display("FAIL hs_busy_ignore: got %0d done pulses want 1", dn); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_proportional();
    test_saturation();
    test_integral_clear();
    test_antiwindup();
    test_derivative();
    test_reset_handshake();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
